// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch stage: opcodes, BHT geometry, immediate decoders.
package pc_fetch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int         BHT_DEPTH = 16;
    localparam int         BHT_IDX_W = 4;
    localparam logic [1:0] BHT_RST   = 2'b01;

    // Where the next sequential-or-redirected fetch address comes from.
    typedef enum logic [1:0] {
        PRED_SEQ,
        PRED_JAL,
        PRED_BRANCH
    } pred_src_e;

    // Sign-extended J-type immediate.
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Sign-extended B-type immediate.
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Link between the fetch stage and its branch history table: one read port, one update port.
interface pc_fetch_if
    import pc_fetch_pkg::*;
();
    logic [BHT_IDX_W-1:0] rd_idx;
    logic [1:0]           rd_ctr;
    logic                 upd_en;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic                 upd_taken;

    modport master (
        output rd_idx, upd_en, upd_idx, upd_taken,
        input  rd_ctr
    );

    modport slave (
        input  rd_idx, upd_en, upd_idx, upd_taken,
        output rd_ctr
    );
endinterface

// File: rtl/pc_fetch_bht.sv
// Branch history table: 16 saturating 2-bit counters, asynchronous read, synchronous update.
module pc_bht
    import pc_fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    pc_fetch_if.slave bht
);

    logic [1:0] ctr_q [BHT_DEPTH];
    logic [1:0] ctr_d [BHT_DEPTH];

    // The read port sees the registered value, so a same-cycle update is not yet visible.
    assign bht.rd_ctr = ctr_q[bht.rd_idx];

    // Saturating increment on taken, saturating decrement on not-taken.
    always_comb begin
        ctr_d = ctr_q;
        if (bht.upd_en) begin
            if (bht.upd_taken) begin
                if (ctr_q[bht.upd_idx] != 2'b11) begin
                    ctr_d[bht.upd_idx] = ctr_q[bht.upd_idx] + 2'b01;
                end
            end else begin
                if (ctr_q[bht.upd_idx] != 2'b00) begin
                    ctr_d[bht.upd_idx] = ctr_q[bht.upd_idx] - 2'b01;
                end
            end
        end
    end

    // Reset wipes all history back to weakly not-taken and drops any concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                ctr_q[i] <= BHT_RST;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: PC register, next-PC selection and branch prediction.
// Macro PC_FETCH_BHT_EN selects a dynamic BHT; otherwise branches use static backward-taken.
module pc_fetch
    import pc_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush_i,
    input  logic [31:0] flushTarget_i,
    input  logic        bhtUpd_i,
    input  logic [31:0] bhtUpdPC_i,
    input  logic        bhtTaken_i,
    input  logic [31:0] instData_i,
    output logic [31:0] instAddr_o,
    output logic [31:0] ifPC,
    output logic [31:0] ifInst,
    output logic        Predict_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pred_pc;
    pred_src_e   pred_src;

    pc_fetch_if bht_if ();

    assign bht_if.rd_idx    = pc_q[5:2];
    assign bht_if.upd_en    = bhtUpd_i;
    assign bht_if.upd_idx   = bhtUpdPC_i[5:2];
    assign bht_if.upd_taken = bhtTaken_i;

`ifdef PC_FETCH_BHT_EN
    pc_bht u_bht (
        .clk (clk),
        .rst (rst),
        .bht (bht_if)
    );
`else
    // Static rule expressed as a counter value: negative offset reads as weakly taken.
    assign bht_if.rd_ctr = instData_i[31] ? 2'b10 : BHT_RST;
`endif

    assign instAddr_o = pc_q;
    assign ifPC       = pc_q;
    assign ifInst     = instData_i;
    assign Predict_o  = (pred_src != PRED_SEQ) && !rst;

    // Decode the fetched word for a prediction, then choose the next PC by priority.
    always_comb begin
        pred_src = PRED_SEQ;
        pred_pc  = pc_q + 32'd4;
        case (instData_i[6:0])
            OP_JAL: begin
                pred_src = PRED_JAL;
                pred_pc  = pc_q + imm_j(instData_i);
            end
            OP_BRANCH: begin
                if (bht_if.rd_ctr[1]) begin
                    pred_src = PRED_BRANCH;
                    pred_pc  = pc_q + imm_b(instData_i);
                end
            end
            OP_JALR: begin
                pred_src = PRED_SEQ;
            end
            default: begin
                pred_src = PRED_SEQ;
            end
        endcase

        pc_d = pred_pc;
        if (flush_i) begin
            pc_d = flushTarget_i;
        end else if (stall[0]) begin
            pc_d = pc_q;
        end
    end

    // PC register with synchronous reset to address zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed vector table, build-specific branch
// sequences, then randomized traffic against a behavioural model.
// Honours PC_FETCH_BHT_EN the same way the design does.
module tb_pc_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JALR = 32'h0000_80E7;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush_i;
    logic [31:0] flushTarget_i;
    logic        bhtUpd_i;
    logic [31:0] bhtUpdPC_i;
    logic        bhtTaken_i;
    logic [31:0] instData_i;
    logic [31:0] instAddr_o;
    logic [31:0] ifPC;
    logic [31:0] ifInst;
    logic        Predict_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0]  st;
        logic        fl;
        logic [31:0] tgt;
        logic [31:0] inst;
        logic [31:0] exp_pc;
        logic        exp_pred;
    } vec_t;

    vec_t vecs[20];

    logic [31:0] m_pc;
    int          m_ctr[16];

    pc_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush_i       (flush_i),
        .flushTarget_i (flushTarget_i),
        .bhtUpd_i      (bhtUpd_i),
        .bhtUpdPC_i    (bhtUpdPC_i),
        .bhtTaken_i    (bhtTaken_i),
        .instData_i    (instData_i),
        .instAddr_o    (instAddr_o),
        .ifPC          (ifPC),
        .ifInst        (ifInst),
        .Predict_o     (Predict_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hang guard.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] enc_jal(input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input logic [31:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Drive one cycle's inputs just after the falling edge and let them settle.
    task automatic applyStimulus(input logic r, input logic [5:0] st, input logic fl,
                                 input logic [31:0] tgt, input logic up,
                                 input logic [31:0] upc, input logic tk,
                                 input logic [31:0] inst);
        @(negedge clk);
        rst           = r;
        stall         = st;
        flush_i       = fl;
        flushTarget_i = tgt;
        bhtUpd_i      = up;
        bhtUpdPC_i    = upc;
        bhtTaken_i    = tk;
        instData_i    = inst;
        #1;
    endtask

    // Compare the combinational view of the fetch stage for the current cycle.
    task automatic checkOutput(input string name, input logic [31:0] exp_pc,
                               input logic exp_pred, input logic [31:0] exp_inst);
        n_tests++;
        if (ifPC !== exp_pc || instAddr_o !== exp_pc) begin
            n_fail++;
            $display("[TB] FAIL %s pc: ifPC=%h instAddr=%h expected %h", name, ifPC, instAddr_o, exp_pc);
        end
        n_tests++;
        if (Predict_o !== exp_pred) begin
            n_fail++;
            $display("[TB] FAIL %s predict: got %b expected %b (pc %h)", name, Predict_o, exp_pred, exp_pc);
        end
        n_tests++;
        if (ifInst !== exp_inst) begin
            n_fail++;
            $display("[TB] FAIL %s inst: got %h expected %h", name, ifInst, exp_inst);
        end
    endtask

    // One plain cycle: no reset, no BHT update.
    task automatic cyc(input string name, input logic [5:0] st, input logic fl,
                       input logic [31:0] tgt, input logic [31:0] inst,
                       input logic [31:0] exp_pc, input logic exp_pred);
        applyStimulus(1'b0, st, fl, tgt, 1'b0, 32'h0, 1'b0, inst);
        checkOutput(name, exp_pc, exp_pred, inst);
    endtask

    // One cycle carrying a BHT update.
    task automatic cycU(input string name, input logic [5:0] st, input logic [31:0] inst,
                        input logic [31:0] upc, input logic tk,
                        input logic [31:0] exp_pc, input logic exp_pred);
        applyStimulus(1'b0, st, 1'b0, 32'h0, 1'b1, upc, tk, inst);
        checkOutput(name, exp_pc, exp_pred, inst);
    endtask

    // Main test sequence.
    initial begin
        logic [31:0] beq;
        logic [31:0] inst;
        logic [31:0] tgt;
        logic [31:0] upc;
        logic [31:0] tmp;
        logic [5:0]  st;
        logic        r;
        logic        fl;
        logic        up;
        logic        tk;
        logic        exp_pred;
        int          kind;
        int          imm;
        int          idx;

        vecs[0]  = '{6'b000000, 1'b0, 32'h0,        NOP,                     32'h0000_0000, 1'b0};
        vecs[1]  = '{6'b000000, 1'b0, 32'h0,        NOP,                     32'h0000_0004, 1'b0};
        vecs[2]  = '{6'b000000, 1'b0, 32'h0,        NOP,                     32'h0000_0008, 1'b0};
        vecs[3]  = '{6'b000000, 1'b0, 32'h0,        NOP,                     32'h0000_000C, 1'b0};
        vecs[4]  = '{6'b000000, 1'b0, 32'h0,        enc_jal(32'h20),         32'h0000_0010, 1'b1};
        vecs[5]  = '{6'b000000, 1'b1, 32'h40,       NOP,                     32'h0000_0030, 1'b0};
        vecs[6]  = '{6'b000000, 1'b0, 32'h0,        enc_jal(32'hFFFF_FFF8),  32'h0000_0040, 1'b1};
        vecs[7]  = '{6'b000000, 1'b1, 32'h8,        NOP,                     32'h0000_0038, 1'b0};
        vecs[8]  = '{6'b000001, 1'b0, 32'h0,        NOP,                     32'h0000_0008, 1'b0};
        vecs[9]  = '{6'b000001, 1'b0, 32'h0,        NOP,                     32'h0000_0008, 1'b0};
        vecs[10] = '{6'b000001, 1'b1, 32'h100,      NOP,                     32'h0000_0008, 1'b0};
        vecs[11] = '{6'b000000, 1'b0, 32'h0,        JALR,                    32'h0000_0100, 1'b0};
        vecs[12] = '{6'b000001, 1'b0, 32'h0,        enc_jal(32'h20),         32'h0000_0104, 1'b1};
        vecs[13] = '{6'b000001, 1'b1, 32'hFFFF_FFFC, enc_jal(32'h20),        32'h0000_0104, 1'b1};
        vecs[14] = '{6'b000000, 1'b0, 32'h0,        enc_jal(32'h8),          32'hFFFF_FFFC, 1'b1};
        vecs[15] = '{6'b000000, 1'b0, 32'h0,        NOP,                     32'h0000_0004, 1'b0};
        vecs[16] = '{6'b000000, 1'b0, 32'h0,        enc_jal(32'hFFFF_FFF8),  32'h0000_0008, 1'b1};
        vecs[17] = '{6'b000000, 1'b0, 32'h0,        NOP,                     32'h0000_0000, 1'b0};
        vecs[18] = '{6'b111110, 1'b0, 32'h0,        NOP,                     32'h0000_0004, 1'b0};
        vecs[19] = '{6'b000000, 1'b0, 32'h0,        NOP,                     32'h0000_0008, 1'b0};

        // Reset for two cycles; a concurrent flush and update must be ignored.
        applyStimulus(1'b1, 6'b0, 1'b1, 32'h500, 1'b1, 32'h20, 1'b1, enc_jal(32'h20));
        applyStimulus(1'b1, 6'b0, 1'b1, 32'h500, 1'b1, 32'h20, 1'b1, enc_jal(32'h20));
        checkOutput("reset", 32'h0, 1'b0, enc_jal(32'h20));

        // Directed vector table.
        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, vecs[i].tgt,
                vecs[i].inst, vecs[i].exp_pc, vecs[i].exp_pred);
        end

`ifdef PC_FETCH_BHT_EN
        // Train, saturate and drain the entry at index 8, then reset mid-run.
        beq = enc_br(32'h10, 3'b000);
        cyc ("bht_go",   6'b0, 1'b1, 32'h20, NOP, 32'h0C, 1'b0);
        cyc ("bht_init", 6'b1, 1'b0, 32'h0,  beq, 32'h20, 1'b0);
        cycU("bht_t1",   6'b1, beq, 32'h20, 1'b1, 32'h20, 1'b0);
        cycU("bht_t2",   6'b1, beq, 32'h20, 1'b1, 32'h20, 1'b1);
        cyc ("bht_jump", 6'b0, 1'b0, 32'h0,  beq, 32'h20, 1'b1);
        cyc ("bht_tgt",  6'b0, 1'b1, 32'h20, NOP, 32'h30, 1'b0);
        cycU("bht_n1",   6'b1, beq, 32'h20, 1'b0, 32'h20, 1'b1);
        cycU("bht_n2",   6'b1, beq, 32'h20, 1'b0, 32'h20, 1'b1);
        cycU("bht_n3",   6'b1, beq, 32'h20, 1'b0, 32'h20, 1'b0);
        cycU("bht_n4",   6'b1, beq, 32'h20, 1'b0, 32'h20, 1'b0);
        cycU("bht_n5",   6'b1, beq, 32'h20, 1'b0, 32'h20, 1'b0);
        cycU("bht_u1",   6'b1, beq, 32'h20, 1'b1, 32'h20, 1'b0);
        cyc ("bht_u1c",  6'b1, 1'b0, 32'h0,  beq, 32'h20, 1'b0);
        cycU("bht_u2",   6'b1, beq, 32'h20, 1'b1, 32'h20, 1'b0);
        cycU("bht_u3",   6'b1, beq, 32'h20, 1'b1, 32'h20, 1'b1);
        cycU("bht_alias",6'b1, beq, 32'h60, 1'b0, 32'h20, 1'b1);
        cycU("bht_idx9", 6'b1, beq, 32'h24, 1'b0, 32'h20, 1'b1);
        cyc ("bht_hold", 6'b1, 1'b0, 32'h0,  beq, 32'h20, 1'b1);
        applyStimulus(1'b1, 6'b0, 1'b1, 32'h80, 1'b1, 32'h20, 1'b1, beq);
        checkOutput("bht_rst", 32'h20, 1'b0, beq);
        cyc ("bht_rpc",  6'b0, 1'b1, 32'h20, NOP, 32'h0, 1'b0);
        cyc ("bht_rctr", 6'b0, 1'b0, 32'h0,  beq, 32'h20, 1'b0);
        cyc ("bht_seq",  6'b0, 1'b0, 32'h0,  NOP, 32'h24, 1'b0);
`else
        // Static backward-taken branches.
        cyc("st_bne_bk", 6'b0, 1'b0, 32'h0, enc_br(32'hFFFF_FFFC, 3'b001), 32'h0C, 1'b1);
        cyc("st_after1", 6'b0, 1'b0, 32'h0, NOP,                           32'h08, 1'b0);
        cyc("st_bne_fw", 6'b0, 1'b0, 32'h0, enc_br(32'h4, 3'b001),         32'h0C, 1'b0);
        cyc("st_after2", 6'b0, 1'b0, 32'h0, NOP,                           32'h10, 1'b0);
        cyc("st_ign_upd",6'b0, 1'b0, 32'h0, NOP,                           32'h14, 1'b0);
        cyc("st_beq_bk", 6'b0, 1'b0, 32'h0, enc_br(32'hFFFF_FFF0, 3'b000), 32'h18, 1'b1);
        cyc("st_after3", 6'b0, 1'b0, 32'h0, NOP,                           32'h08, 1'b0);
`endif

        // Randomized traffic against the behavioural model, from a fresh reset.
        applyStimulus(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP);
        m_pc = 32'h0;
        for (int i = 0; i < 16; i++) m_ctr[i] = 1;

        for (int c = 0; c < 1500; c++) begin
            kind = $urandom_range(0, 9);
            imm  = 0;
            if (kind <= 2) begin
                inst = NOP;
            end else if (kind <= 4) begin
                imm  = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                inst = enc_jal(32'(imm));
            end else if (kind <= 7) begin
                imm  = (int'($urandom_range(0, 4095)) - 2048) * 2;
                tmp  = $urandom;
                inst = enc_br(32'(imm), tmp[2:0] == 3'd2 || tmp[2:0] == 3'd3 ? 3'd0 : tmp[2:0]);
            end else if (kind == 8) begin
                inst = $urandom;
                inst[6:0] = 7'b1100111;
            end else begin
                inst = $urandom;
                inst[6:0] = 7'b0110011;
            end

            r   = ($urandom_range(0, 63) == 0);
            tmp = $urandom;
            st  = tmp[5:0];
            st[0] = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            tgt = $urandom;
            tgt = tgt & 32'hFFFF_FFFC;
            up  = $urandom_range(0, 1);
            upc = ($urandom_range(0, 1) == 1) ? m_pc : $urandom;
            tk  = $urandom_range(0, 1);

            idx = int'((m_pc >> 2) % 16);
            if (r) begin
                exp_pred = 1'b0;
            end else if (kind == 3 || kind == 4) begin
                exp_pred = 1'b1;
            end else if (kind >= 5 && kind <= 7) begin
`ifdef PC_FETCH_BHT_EN
                exp_pred = (m_ctr[idx] >= 2);
`else
                exp_pred = (imm < 0);
`endif
            end else begin
                exp_pred = 1'b0;
            end

            applyStimulus(r, st, fl, tgt, up, upc, tk, inst);
            checkOutput("rnd", m_pc, exp_pred, inst);

            if (r) begin
                m_pc = 32'h0;
                for (int i = 0; i < 16; i++) m_ctr[i] = 1;
            end else begin
                if (fl)            m_pc = tgt;
                else if (st[0])    m_pc = m_pc;
                else if (exp_pred) m_pc = m_pc + 32'(imm);
                else               m_pc = m_pc + 32'd4;
                if (up) begin
                    idx = int'((upc >> 2) % 16);
                    if (tk) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    else    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port stall  input  6  pipeline stall vector; bit 0 = hold PC.
REQ-004 SHALL have port flush_i  input  1  branch/jump misprediction redirect from EX.
REQ-005 SHALL have port flushTarget_i  input  32  corrected PC accompanying flush_i.
REQ-006 SHALL have port bhtUpd_i  input  1  resolved conditional branch update strobe.
REQ-007 SHALL have port bhtUpdPC_i  input  32  PC of the resolved branch.
REQ-008 SHALL have port bhtTaken_i  input  1  resolved direction, 1 = taken.
REQ-009 SHALL have port instData_i  input  32  instruction word from combinational instruction ROM.
REQ-010 SHALL have port instAddr_o  output  32  ROM address, equal to current PC.
REQ-011 SHALL have port ifPC  output  32  current PC to IF/ID register.
REQ-012 SHALL have port ifInst  output  32  fetched instruction to IF/ID register.
REQ-013 SHALL have port Predict_o  output  1  1 = fetch stage predicted taken for this instruction.

Function
REQ-014 instAddr_o and ifPC SHALL equal the PC register; ifInst SHALL equal instData_i combinationally (zero-latency ROM).
REQ-015 Next-PC priority SHALL be: rst -> 0; flush_i -> flushTarget_i; stall[0] -> hold; predicted taken -> PC + imm; else PC + 4.
REQ-016 flush_i SHALL override stall[0] in the same cycle.
REQ-017 All PC arithmetic SHALL be 32-bit, wrapping modulo 2^32.
REQ-018 JAL (opcode 1101111) SHALL always be predicted taken, target = PC + sign-extended J-immediate.
REQ-019 Conditional branches (opcode 1100011) SHALL be predicted per REQ-022/REQ-027, target = PC + sign-extended B-immediate.
REQ-020 JALR and all other opcodes SHALL be predicted not-taken, with Predict_o = 0.
REQ-021 Predict_o SHALL be combinational, valid every cycle including stall, and 0 while rst is high.
REQ-022 With BHT_EN: 16-entry table of 2-bit counters, indexed by PC[5:2]; predict taken iff counter[1] = 1.
REQ-023 BHT update on bhtUpd_i, indexed by bhtUpdPC_i[5:2]: taken -> increment, saturating at 3; not-taken -> decrement, saturating at 0.
REQ-024 BHT updates SHALL proceed regardless of stall and flush.
REQ-025 Same-cycle read and update of one entry SHALL predict from the pre-update value (read-before-write).

Reset
REQ-026 On rst, the PC SHALL be 0 on the next edge, every BHT counter SHALL be 2'b01 (weakly not-taken), and a concurrent flush or update SHALL be ignored; reset mid-operation discards all history.

Configuration
REQ-027 Macro PC_FETCH_BHT_EN: when defined, dynamic BHT per REQ-022..025; when undefined, no BHT storage, bht* inputs ignored, and conditional branches predicted taken iff instData_i[31] = 1 (static backward-taken).

Structure
REQ-028 Shared package SHALL hold opcode constants (OP_BRANCH, OP_JAL, OP_JALR), BHT_DEPTH = 16, BHT_IDX_W = 4, and BHT_RST = 2'b01.
REQ-029 The BHT SHALL be a sub-module pc_bht (read port, update port, reset), instantiated only under PC_FETCH_BHT_EN.

Verification
REQ-030 Reset, then 3 cycles of free-run with NOPs -> ifPC = 0, 4, 8, 12; Predict_o = 0.
REQ-031 At PC 0x10, JAL with imm +0x20 -> Predict_o = 1; next ifPC = 0x30; at PC 0x40, JAL imm -8 -> next 0x38.
REQ-032 stall[0] = 1 for 2 cycles at PC 0x8 -> ifPC stays 0x8; flush_i with target 0x100 during stall -> next ifPC = 0x100.
REQ-033 BHT_EN: BEQ at 0x20 (imm +0x10), two taken updates -> Predict_o 0, then 0 after first update, 1 after second, next PC 0x30; five not-taken updates -> counter 0, then no further underflow.
REQ-034 Update to index 8 in the same cycle as fetch from 0x20 -> prediction uses old counter; rst asserted mid-run -> PC = 0 and all counters return to 01.
REQ-035 Without BHT_EN: BNE with imm -4 -> Predict_o = 1, next PC = PC - 4; BNE with imm +4 -> Predict_o = 0.
